// File: rtl/reg_dump_reader_pkg.sv
// Shared definitions for the register dump reader and the trace monitor that consumes it.
package reg_dump_reader_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  localparam int NUM_REGS_DEF = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int DATA_W_DEF   = 32;

endpackage

// File: rtl/reg_dump_reader_if.sv
// Valid/ready stream carrying one {index, value} register pair per transfer.
interface reg_dump_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);

  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] data;

  modport master (output valid, output idx, output data, input ready);
  modport slave  (input valid, input idx, input data, output ready);

endinterface

// File: rtl/reg_dump_reader.sv
// Walks the register file through a spare combinational read port on a start pulse and
// streams every {index, value} pair out, one pair per cycle when the consumer keeps up.
//
// state  | meaning
// IDLE   | waiting for start; read address parked on rd_ptr
// LOAD   | one cycle: read address = first index, capture first pair
// SEND   | pair presented; read address prefetches out_idx+1 for the next capture
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter bit SKIP_X0  = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  output logic [ADDR_W-1:0]  rf_raddr_o,
  input  logic [DATA_W-1:0]  rf_rdata_i,
  output logic               rf_hold_o,
  output logic               busy_o,
  output logic               done_o,
  reg_dump_reader_if.master  out_if
);

  localparam logic [ADDR_W-1:0] FIRST = SKIP_X0 ? ADDR_W'(1) : ADDR_W'(0);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REGS - 1);

  logic [1:0]        state_q,     state_d;
  logic [ADDR_W-1:0] rd_ptr_q,    rd_ptr_d;
  logic [ADDR_W-1:0] out_idx_q,   out_idx_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              done_q,      done_d;

  logic handshake;
  assign handshake = out_valid_q && out_if.ready;

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    out_idx_d   = out_idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    rf_raddr_o  = rd_ptr_q;
    case (state_q)
      S_IDLE: begin
        // the done cycle is still IDLE, so a start there must be dropped explicitly
        if (start_i && !done_q) begin
          rd_ptr_d = FIRST;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        rf_raddr_o  = rd_ptr_q;
        out_data_d  = rf_rdata_i;
        out_idx_d   = rd_ptr_q;
        out_valid_d = 1'b1;
        state_d     = S_SEND;
      end
      S_SEND: begin
        // at the last index this address wraps, but it is never captured
        rf_raddr_o = out_idx_q + ADDR_W'(1);
        if (handshake) begin
          if (out_idx_q == LAST) begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = S_IDLE;
          end else begin
            out_data_d = rf_rdata_i;
            out_idx_d  = out_idx_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign rf_hold_o    = (state_q != S_IDLE);
  assign done_o       = done_q;
  assign out_if.valid = out_valid_q;
  assign out_if.idx   = out_idx_q;
  assign out_if.data  = out_data_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench: register file model preloaded with x[i]=A000_0000+i, two readers
// (full walk and x0-skipping walk) sharing it.
module tb_reg_dump_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start1 = 1'b0, start2 = 1'b0;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        hold1, hold2, busy1, busy2, done1, done2;

  logic [31:0] rf [32];
  logic        reload = 1'b1;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) if1 ();
  reg_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) if2 ();

  reg_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .SKIP_X0(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .rf_raddr_o(raddr1), .rf_rdata_i(rdata1),
    .rf_hold_o(hold1), .busy_o(busy1), .done_o(done1), .out_if(if1.master));

  reg_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .SKIP_X0(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_i(start2), .rf_raddr_o(raddr2), .rf_rdata_i(rdata2),
    .rf_hold_o(hold2), .busy_o(busy2), .done_o(done2), .out_if(if2.master));

  always @(posedge clk) begin
    if (reload) begin
      for (int k = 0; k < 32; k++) rf[k] <= 32'hA000_0000 + 32'(k);
    end else if (wr_en) begin
      rf[wr_addr] <= wr_data;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? 32'h0 : rf[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'h0 : rf[raddr2];

  function automatic logic [31:0] exp_val(int i);
    return (i == 0) ? 32'h0 : 32'hA000_0000 + 32'(i);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    if1.ready = 1'b1;
    if2.ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({if1.valid, busy1, hold1, done1} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b want=0000", {if1.valid, busy1, hold1, done1});
    end
    checks++;
    if (if1.idx !== 5'd0 || if1.data !== 32'h0 || raddr1 !== 5'd0) begin
      failures++;
      $display("FAIL reset_regs got idx=%0d data=%h raddr=%0d want 0/0/0", if1.idx, if1.data, raddr1);
    end
    rst_n = 1'b1;
    reload = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_dump();
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    checks++;
    if (busy1 !== 1'b1 || if1.valid !== 1'b0) begin
      failures++;
      $display("FAIL load_cycle got busy=%b valid=%b want busy=1 valid=0", busy1, if1.valid);
    end
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (if1.valid !== 1'b1 || if1.idx !== 5'(i) || if1.data !== exp_val(i)) begin
        failures++;
        $display("FAIL full_pair got v=%b idx=%0d data=%h want v=1 idx=%0d data=%h",
                 if1.valid, if1.idx, if1.data, i, exp_val(i));
      end
      @(negedge clk);
    end
    checks++;
    if (done1 !== 1'b1 || if1.valid !== 1'b0) begin
      failures++;
      $display("FAIL full_done got done=%b valid=%b want done=1 valid=0", done1, if1.valid);
    end
    @(negedge clk);
    checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL full_after got done=%b busy=%b want 0 0", done1, busy1);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0]  pat = 4'b1001;
    int          nexp = 0;
    bit          stalled = 0, seen_done = 0;
    logic [4:0]  h_idx = '0;
    logic [31:0] h_data = '0;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
      if (done1) seen_done = 1;
      if1.ready = pat[3 - (cyc % 4)];
      if (stalled) begin
        checks++;
        if (if1.valid !== 1'b1 || if1.idx !== h_idx || if1.data !== h_data) begin
          failures++;
          $display("FAIL bp_hold got v=%b idx=%0d data=%h want v=1 idx=%0d data=%h",
                   if1.valid, if1.idx, if1.data, h_idx, h_data);
        end
      end
      stalled = 0;
      if (if1.valid && !seen_done) begin
        if (if1.ready) begin
          checks++;
          if (if1.idx !== 5'(nexp) || if1.data !== exp_val(nexp)) begin
            failures++;
            $display("FAIL bp_order got idx=%0d data=%h want idx=%0d data=%h",
                     if1.idx, if1.data, nexp, exp_val(nexp));
          end
          nexp++;
        end else begin
          stalled = 1;
          h_idx   = if1.idx;
          h_data  = if1.data;
        end
      end
      @(negedge clk);
    end
    if1.ready = 1'b1;
    checks++;
    if (nexp != 32 || !seen_done) begin
      failures++;
      $display("FAIL bp_count got pairs=%0d done=%0d want pairs=32 done=1", nexp, seen_done);
    end
  endtask

  task automatic test_skip_x0();
    int  cnt = 0;
    bit  seen_done = 0;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int cyc = 0; cyc < 60 && !seen_done; cyc++) begin
      if (done2) seen_done = 1;
      if (if2.valid) begin
        checks++;
        if (if2.idx !== 5'(cnt + 1) || if2.data !== exp_val(cnt + 1)) begin
          failures++;
          $display("FAIL skip_pair got idx=%0d data=%h want idx=%0d data=%h",
                   if2.idx, if2.data, cnt + 1, exp_val(cnt + 1));
        end
        cnt++;
      end
      @(negedge clk);
    end
    checks++;
    if (cnt != 31 || !seen_done) begin
      failures++;
      $display("FAIL skip_count got pairs=%0d done=%0d want pairs=31 done=1", cnt, seen_done);
    end
  endtask

  task automatic test_coherence();
    int          cnt = 0;
    bit          seen_done = 0;
    logic [31:0] want;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int cyc = 0; cyc < 60 && !seen_done; cyc++) begin
      if (done1) seen_done = 1;
      wr_en = 1'b0;
      if (if1.valid) begin
        want = (cnt == 9) ? 32'hDEAD_BEEF : exp_val(cnt);
        checks++;
        if (if1.idx !== 5'(cnt) || if1.data !== want) begin
          failures++;
          $display("FAIL coh_pair got idx=%0d data=%h want idx=%0d data=%h",
                   if1.idx, if1.data, cnt, want);
        end
        // x9 is written long before its capture; x5 on the very edge that captures it
        if (cnt == 2 || cnt == 4) begin
          wr_en   = 1'b1;
          wr_addr = (cnt == 2) ? 5'd9 : 5'd5;
          wr_data = 32'hDEAD_BEEF;
        end
        cnt++;
      end
      @(negedge clk);
    end
    wr_en = 1'b0;
    checks++;
    if (cnt != 32 || !seen_done) begin
      failures++;
      $display("FAIL coh_count got pairs=%0d done=%0d want pairs=32 done=1", cnt, seen_done);
    end
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic test_start_ignored();
    int cnt = 0;
    bit seen_done = 0;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int cyc = 0; cyc < 60 && !seen_done; cyc++) begin
      start1 = 1'b0;
      if (done1) begin
        seen_done = 1;
        start1 = 1'b1;
      end else begin
        checks++;
        if (busy1 !== 1'b1 || hold1 !== 1'b1) begin
          failures++;
          $display("FAIL ign_busy got busy=%b hold=%b want 1 1 at pair %0d", busy1, hold1, cnt);
        end
        if (if1.valid) begin
          checks++;
          if (if1.idx !== 5'(cnt)) begin
            failures++;
            $display("FAIL ign_order got idx=%0d want %0d", if1.idx, cnt);
          end
          if (cnt == 10) start1 = 1'b1;
          cnt++;
        end
      end
      @(negedge clk);
    end
    start1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (busy1 !== 1'b0 || if1.valid !== 1'b0) begin
        failures++;
        $display("FAIL ign_restart got busy=%b valid=%b want 0 0", busy1, if1.valid);
      end
      @(negedge clk);
    end
    checks++;
    if (cnt != 32 || !seen_done) begin
      failures++;
      $display("FAIL ign_count got pairs=%0d done=%0d want pairs=32 done=1", cnt, seen_done);
    end
  endtask

  task automatic test_reset_mid_dump();
    int cnt = 0;
    bit seen_done = 0;
    bit hit = 0;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int cyc = 0; cyc < 40 && !hit; cyc++) begin
      if (if1.valid && if1.idx == 5'd12) hit = 1;
      else @(negedge clk);
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL rst_reach got idx=%0d want 12", if1.idx);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({if1.valid, busy1, hold1, done1} !== 4'b0000 || if1.idx !== 5'd0 ||
        if1.data !== 32'h0 || raddr1 !== 5'd0) begin
      failures++;
      $display("FAIL rst_async got v/b/h/d=%b idx=%0d data=%h raddr=%0d want all 0",
               {if1.valid, busy1, hold1, done1}, if1.idx, if1.data, raddr1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (done1 !== 1'b0 || busy1 !== 1'b0) begin
        failures++;
        $display("FAIL rst_nodone got done=%b busy=%b want 0 0", done1, busy1);
      end
      @(negedge clk);
    end
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int cyc = 0; cyc < 60 && !seen_done; cyc++) begin
      if (done1) seen_done = 1;
      if (if1.valid) begin
        checks++;
        if (if1.idx !== 5'(cnt) || if1.data !== exp_val(cnt)) begin
          failures++;
          $display("FAIL rst_redump got idx=%0d data=%h want idx=%0d data=%h",
                   if1.idx, if1.data, cnt, exp_val(cnt));
        end
        cnt++;
      end
      @(negedge clk);
    end
    checks++;
    if (cnt != 32 || !seen_done) begin
      failures++;
      $display("FAIL rst_count got pairs=%0d done=%0d want pairs=32 done=1", cnt, seen_done);
    end
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_backpressure();
    test_skip_x0();
    test_coherence();
    test_start_ignored();
    test_reset_mid_dump();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
